// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ops resolve combinationally,
// DIV/DIVU run on an iterative restoring divider that stalls upstream stages.
module ex_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int OP_W       = 8,
    parameter int SEL_W      = 3,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [OP_W-1:0]   ex_alu_op,
    input  logic [SEL_W-1:0]  ex_alu_sel,
    input  logic [DATA_W-1:0] ex_reg_data_1,
    input  logic [DATA_W-1:0] ex_reg_data_2,
    input  logic [ADDR_W-1:0] ex_reg_write_addr,
    input  logic              ex_reg_write_en,
    output logic              stall_req,
    output logic [ADDR_W-1:0] mem_reg_write_addr,
    output logic              mem_reg_write_en,
    output logic [DATA_W-1:0] mem_reg_write_data,
    output logic              mem_hilo_write_en,
    output logic [DATA_W-1:0] mem_hi,
    output logic [DATA_W-1:0] mem_lo
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DIVZ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] dvs_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              q_neg_r;
    logic              r_neg_r;

    logic [DATA_W-1:0] alu_res_s;
    logic              is_div_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [DATA_W-1:0] a_mag_s;
    logic [DATA_W-1:0] b_mag_s;
    logic [DATA_W:0]   partial_s;
    logic [DATA_W:0]   diff_s;
    logic              ge_s;

    // Single-cycle ALU result and divider operand preparation
    always_comb begin
        alu_res_s = {DATA_W{1'b0}};
        is_div_s  = 1'b0;
        case (ex_alu_sel)
            3'd1: begin
                case (ex_alu_op)
                    8'd0:    alu_res_s = ex_reg_data_1 & ex_reg_data_2;
                    8'd1:    alu_res_s = ex_reg_data_1 | ex_reg_data_2;
                    8'd2:    alu_res_s = ex_reg_data_1 ^ ex_reg_data_2;
                    8'd3:    alu_res_s = ~(ex_reg_data_1 | ex_reg_data_2);
                    default: alu_res_s = {DATA_W{1'b0}};
                endcase
            end
            3'd2: begin
                case (ex_alu_op)
                    8'd0:    alu_res_s = ex_reg_data_1 << ex_reg_data_2[4:0];
                    8'd1:    alu_res_s = ex_reg_data_1 >> ex_reg_data_2[4:0];
                    8'd2:    alu_res_s = $unsigned($signed(ex_reg_data_1) >>> ex_reg_data_2[4:0]);
                    default: alu_res_s = {DATA_W{1'b0}};
                endcase
            end
            3'd3: begin
                case (ex_alu_op)
                    8'd0:    alu_res_s = ex_reg_data_1 + ex_reg_data_2;
                    8'd1:    alu_res_s = ex_reg_data_1 - ex_reg_data_2;
                    8'd2:    alu_res_s = {{(DATA_W-1){1'b0}}, $signed(ex_reg_data_1) < $signed(ex_reg_data_2)};
                    8'd3:    alu_res_s = {{(DATA_W-1){1'b0}}, ex_reg_data_1 < ex_reg_data_2};
                    default: alu_res_s = {DATA_W{1'b0}};
                endcase
            end
            3'd4: begin
                is_div_s = (ex_alu_op == 8'd0) || (ex_alu_op == 8'd1);
            end
            default: alu_res_s = {DATA_W{1'b0}};
        endcase

        // Only signed DIV converts to magnitudes; 0x80000000 stays itself as unsigned
        a_neg_s = (ex_alu_op == 8'd0) && ex_reg_data_1[DATA_W-1];
        b_neg_s = (ex_alu_op == 8'd0) && ex_reg_data_2[DATA_W-1];
        a_mag_s = a_neg_s ? (~ex_reg_data_1 + {{(DATA_W-1){1'b0}}, 1'b1}) : ex_reg_data_1;
        b_mag_s = b_neg_s ? (~ex_reg_data_2 + {{(DATA_W-1){1'b0}}, 1'b1}) : ex_reg_data_2;

        partial_s = {rem_r, quo_r[DATA_W-1]};
        diff_s    = partial_s - {1'b0, dvs_r};
        ge_s      = ~diff_s[DATA_W];
    end

    // Divider FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            quo_r   <= {DATA_W{1'b0}};
            rem_r   <= {DATA_W{1'b0}};
            dvs_r   <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (flush) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (is_div_s) begin
                        quo_r   <= a_mag_s;
                        rem_r   <= {DATA_W{1'b0}};
                        dvs_r   <= b_mag_s;
                        q_neg_r <= a_neg_s ^ b_neg_s;
                        r_neg_r <= a_neg_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= (ex_reg_data_2 == {DATA_W{1'b0}}) ? S_DIVZ : S_RUN;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_r <= ge_s ? diff_s[DATA_W-1:0] : partial_s[DATA_W-1:0];
                    quo_r <= {quo_r[DATA_W-2:0], ge_s};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(DIV_CYCLES - 1)) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DIVZ: begin
                    // Divide by zero: remainder is the dividend magnitude, sign restored in DONE
                    rem_r   <= quo_r;
                    quo_r   <= {DATA_W{1'b0}};
                    state_r <= S_DONE;
                end
                S_DONE:  state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Output steering; reset and flush squash everything
    always_comb begin
        stall_req          = 1'b0;
        mem_reg_write_addr = {ADDR_W{1'b0}};
        mem_reg_write_en   = 1'b0;
        mem_reg_write_data = {DATA_W{1'b0}};
        mem_hilo_write_en  = 1'b0;
        mem_hi             = {DATA_W{1'b0}};
        mem_lo             = {DATA_W{1'b0}};
        if (rst || flush) begin
            stall_req = 1'b0;
        end else begin
            mem_reg_write_addr = ex_reg_write_addr;
            mem_reg_write_en   = ex_reg_write_en;
            mem_reg_write_data = alu_res_s;
            stall_req = ((state_r == S_IDLE) && is_div_s) ||
                        (state_r == S_RUN) || (state_r == S_DIVZ);
            if (state_r == S_DONE) begin
                mem_hilo_write_en = 1'b1;
                mem_lo = q_neg_r ? (~quo_r + {{(DATA_W-1){1'b0}}, 1'b1}) : quo_r;
                mem_hi = r_neg_r ? (~rem_r + {{(DATA_W-1){1'b0}}, 1'b1}) : rem_r;
            end else begin
                mem_hilo_write_en = 1'b0;
            end
        end
    end

endmodule
